// File: rtl/mcp_tx_fifo_if.sv
// mcp_tx_fifo_if
// Groups the producer push port and the MCP launch/ack pair of the transmit
// endpoint.
//   wdata/wvalid/wready : producer valid/ready push port
//   tx_data/tx_en       : held data bus and launch toggle to the receiver
//   rx_ack              : acknowledge toggle from the receiver (asynchronous)
// slave  : the FIFO/launcher side
// master : the producer/receiver environment side
interface mcp_tx_fifo_if #(
    parameter int DW = 8
);
    logic [DW-1:0] wdata;
    logic          wvalid;
    logic          wready;
    logic [DW-1:0] tx_data;
    logic          tx_en;
    logic          rx_ack;

    modport slave (
        input  wdata,
        input  wvalid,
        output wready,
        output tx_data,
        output tx_en,
        input  rx_ack
    );

    modport master (
        output wdata,
        output wvalid,
        input  wready,
        input  tx_data,
        input  tx_en,
        output rx_ack
    );
endinterface

// File: rtl/mcp_tx_fifo.sv
// mcp_tx_fifo
// Transmit endpoint of a toggle-based multi-cycle-path crossing. Words pushed
// by a local producer are buffered in a small FIFO and launched one at a time
// onto a held data bus with a toggling enable. The next word is launched only
// after the receiver's acknowledge toggle has been synchronized back.
//
// Ports
//   i_clk     : clock, all state updates on the rising edge
//   i_rst     : synchronous active-high reset
//   io_bus    : push port and launch/ack pair (mcp_tx_fifo_if.slave)
//   o_count   : words held in the FIFO, excluding the word in flight
//   o_busy    : a word is in flight and awaiting ack
//   o_ack_err : sticky, an ack toggle arrived with no word in flight
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | nothing in flight; launch the FIFO head if one is present
// ST_BUSY | word on tx_data held stable, waiting for the ack toggle
module mcp_tx_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    mcp_tx_fifo_if.slave             io_bus,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_busy,
    output logic                     o_ack_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [DW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [DW-1:0]   r_tx_data;
    logic            r_tx_en;
    logic            r_ack_q1;
    logic            r_ack_q2;
    logic            r_ack_q3;
    logic            r_ack_err;

    logic            w_wready;
    logic            w_push;
    logic            w_launch;
    logic            w_ack_pulse;
    logic            w_ack_err_set;

    assign w_wready    = (r_count < CW'(DEPTH));
    assign w_push      = io_bus.wvalid & w_wready;
    // q2 vs q3 compares the synchronized ack level with its previous value;
    // any difference is one receiver acknowledge.
    assign w_ack_pulse = r_ack_q2 ^ r_ack_q3;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_launch      = 1'b0;
        w_ack_err_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // An ack here has no word to retire; flag it and carry on.
                if (w_ack_pulse) begin
                    w_ack_err_set = 1'b1;
                end
                if (r_count != '0) begin
                    w_launch    = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // No launch on the ack edge; the next launch comes from IDLE.
                if (w_ack_pulse) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Storage is not reset; only slots between the pointers are ever read.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_push) begin
            r_mem[r_wptr] <= io_bus.wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_tx_data <= '0;
            r_tx_en   <= 1'b0;
            r_ack_q1  <= 1'b0;
            r_ack_q2  <= 1'b0;
            r_ack_q3  <= 1'b0;
            r_ack_err <= 1'b0;
        end else begin
            r_ack_q1 <= io_bus.rx_ack;
            r_ack_q2 <= r_ack_q1;
            r_ack_q3 <= r_ack_q2;

            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end

            if (w_launch) begin
                r_tx_data <= r_mem[r_rptr];
                r_tx_en   <= ~r_tx_en;
                r_rptr    <= r_rptr + AW'(1);
            end

            case ({w_push, w_launch})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (w_ack_err_set) begin
                r_ack_err <= 1'b1;
            end
        end
    end

    assign io_bus.wready  = w_wready;
    assign io_bus.tx_data = r_tx_data;
    assign io_bus.tx_en   = r_tx_en;
    assign o_count        = r_count;
    assign o_busy         = (r_state == ST_BUSY);
    assign o_ack_err      = r_ack_err;

endmodule

// File: tb/tb_mcp_tx_fifo.sv
// tb_mcp_tx_fifo
// Directed and randomized stimulus for mcp_tx_fifo, checked every cycle
// against a transaction-level model: a queue of buffered words, an in-flight
// flag, and a schedule of the edges at which each ack toggle takes effect.
module tb_mcp_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [2:0] count;
    logic       busy;
    logic       ack_err;

    mcp_tx_fifo_if #(.DW(DW)) bus ();

    mcp_tx_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .io_bus    (bus),
        .o_count   (count),
        .o_busy    (busy),
        .o_ack_err (ack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int edge_no = 0;

    logic [7:0] m_q[$];
    int         pend[$];
    bit         m_inflight = 0;
    logic [7:0] m_tx_data  = '0;
    logic       m_tx_en    = 1'b0;
    logic       m_err      = 1'b0;
    string      phase      = "init";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("tx_en",   32'(bus.tx_en),   32'(m_tx_en));
        chk("tx_data", 32'(bus.tx_data), 32'(m_tx_data));
        chk("count",   32'(count),       32'(m_q.size()));
        chk("busy",    32'(busy),        32'(m_inflight));
        chk("ack_err", 32'(ack_err),     32'(m_err));
        chk("wready",  32'(bus.wready),  32'(m_q.size() < DEPTH));
    endtask

    // Inputs are driven after the falling edge; the model advances with the
    // next rising edge and the DUT is compared at the following falling edge.
    task automatic tick();
        bit pulse;
        bit push;
        int nxt;
        nxt = edge_no + 1;
        if (rst) begin
            m_q.delete();
            pend.delete();
            m_inflight = 0;
            m_tx_data  = '0;
            m_tx_en    = 1'b0;
            m_err      = 1'b0;
        end else begin
            pulse = 0;
            if (pend.size() > 0 && pend[0] == nxt) begin
                pulse = 1;
                void'(pend.pop_front());
            end
            push = bus.wvalid && (m_q.size() < DEPTH);
            if (!m_inflight) begin
                if (pulse) m_err = 1'b1;
                if (m_q.size() > 0) begin
                    m_tx_data  = m_q.pop_front();
                    m_tx_en    = ~m_tx_en;
                    m_inflight = 1;
                end
            end else if (pulse) begin
                m_inflight = 0;
            end
            if (push) m_q.push_back(bus.wdata);
        end
        @(posedge clk);
        edge_no = nxt;
        @(negedge clk);
        check_all();
    endtask

    // A toggle made now is sampled at edge K = edge_no+1 and retires the
    // word at K+2.
    task automatic toggle_ack();
        bus.rx_ack = ~bus.rx_ack;
        pend.push_back(edge_no + 3);
    endtask

    task automatic ack_word();
        toggle_ack();
        repeat (4) tick();
    endtask

    initial begin
        rst        = 1'b1;
        bus.wvalid = 1'b1;
        bus.wdata  = 8'hEE;
        bus.rx_ack = 1'b0;

        phase = "reset";
        tick();
        tick();
        rst        = 1'b0;
        bus.wvalid = 1'b0;
        chk("rst_count",   32'(count),       32'd0);
        chk("rst_wready",  32'(bus.wready),  32'd1);
        chk("rst_tx_en",   32'(bus.tx_en),   32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        tick();
        chk("rst_nostore", 32'(busy),        32'd0);

        phase = "single";
        bus.wvalid = 1'b1;
        bus.wdata  = 8'hA5;
        tick();
        chk("sw_count1", 32'(count), 32'd1);
        bus.wvalid = 1'b0;
        tick();
        chk("sw_tx_en",   32'(bus.tx_en),   32'd1);
        chk("sw_tx_data", 32'(bus.tx_data), 32'hA5);
        chk("sw_busy",    32'(busy),        32'd1);
        toggle_ack();
        tick();
        tick();
        chk("sw_busy_k1", 32'(busy), 32'd1);
        tick();
        chk("sw_busy_k2", 32'(busy), 32'd0);

        phase = "fill";
        for (int i = 1; i <= 5; i++) begin
            bus.wvalid = 1'b1;
            bus.wdata  = 8'(i);
            tick();
        end
        chk("fill_count",  32'(count),      32'd4);
        chk("fill_wready", 32'(bus.wready), 32'd0);
        bus.wdata = 8'h06;
        repeat (3) tick();
        chk("fill_stall", 32'(count), 32'd4);
        bus.wvalid = 1'b0;
        chk("fill_first", 32'(bus.tx_data), 32'h01);
        for (int i = 2; i <= 5; i++) begin
            ack_word();
            chk("fill_seq", 32'(bus.tx_data), 32'(i));
        end
        phase = "wrap";
        for (int i = 0; i < 3; i++) begin
            bus.wvalid = 1'b1;
            bus.wdata  = 8'($urandom);
            tick();
        end
        bus.wvalid = 1'b0;
        repeat (3) ack_word();
        toggle_ack();
        repeat (3) tick();
        chk("wrap_idle",  32'(busy),  32'd0);
        chk("wrap_empty", 32'(count), 32'd0);

        phase = "pushpop";
        bus.wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.wdata = 8'($urandom);
            tick();
        end
        bus.wvalid = 1'b0;
        chk("pp_count_pre", 32'(count), 32'd2);
        toggle_ack();
        repeat (3) tick();
        bus.wvalid = 1'b1;
        bus.wdata  = 8'($urandom);
        tick();
        bus.wvalid = 1'b0;
        chk("pp_count", 32'(count), 32'd2);
        repeat (2) ack_word();
        toggle_ack();
        repeat (3) tick();

        phase = "spurious";
        toggle_ack();
        tick();
        tick();
        chk("sp_err_k1", 32'(ack_err), 32'd0);
        tick();
        chk("sp_err_k2", 32'(ack_err), 32'd1);
        repeat (3) tick();
        chk("sp_err_held", 32'(ack_err), 32'd1);
        chk("sp_idle",     32'(busy),    32'd0);

        phase = "random";
        for (int c = 0; c < 300; c++) begin
            bus.wvalid = 1'($urandom_range(0, 1));
            bus.wdata  = 8'($urandom);
            if (m_inflight && pend.size() == 0 && $urandom_range(0, 2) == 0) toggle_ack();
            tick();
        end
        bus.wvalid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (m_inflight && pend.size() == 0) toggle_ack();
            tick();
        end

        phase = "midreset";
        bus.wvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.wdata = 8'($urandom);
            tick();
        end
        bus.wvalid = 1'b0;
        chk("mr_count_pre", 32'(count), 32'd3);
        chk("mr_busy_pre",  32'(busy),  32'd1);
        rst        = 1'b1;
        bus.rx_ack = 1'b0;
        tick();
        rst = 1'b0;
        chk("mr_count",   32'(count),       32'd0);
        chk("mr_busy",    32'(busy),        32'd0);
        chk("mr_tx_en",   32'(bus.tx_en),   32'd0);
        chk("mr_tx_data", 32'(bus.tx_data), 32'd0);
        chk("mr_ack_err", 32'(ack_err),     32'd0);
        bus.wvalid = 1'b1;
        bus.wdata  = 8'h3C;
        tick();
        bus.wvalid = 1'b0;
        tick();
        chk("mr_relaunch_en",   32'(bus.tx_en),   32'd1);
        chk("mr_relaunch_data", 32'(bus.tx_data), 32'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
